// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad decimal-entry path.
//   - key code constants produced by the scanner
//   - scanner FSM state enum
//   - keypad_key_code(): (row, column) position -> key code
//   - bcd_to_bin(): four BCD digits -> binary value
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_D     = 4'hD;
  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_NONE  = 4'hF;
  // '#' has no action, so it shares the "no key" encoding.
  localparam logic [3:0] KEY_HASH  = KEY_NONE;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } scan_state_e;

  // Physical layout, row 0 at the top, column 0 on the left:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] keypad_key_code(input logic [1:0] r,
                                                 input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_ENTER;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_BKSP;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_CLR;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // ((d3*10 + d2)*10 + d1)*10 + d0; 9999 fits in 14 bits.
  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    logic [13:0] acc;
    acc = 14'(bcd[15:12]);
    acc = acc * 14'd10 + 14'(bcd[11:8]);
    acc = acc * 14'd10 + 14'(bcd[7:4]);
    acc = acc * 14'd10 + 14'(bcd[3:0]);
    return acc;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 4x4 keypad columns one at a time, samples the
// synchronized rows, debounces press and release, and emits a one-cycle
// key_strobe with key_code for each accepted press.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   row[3:0]         keypad rows, active-low, asynchronous to clk
//   col[3:0]         column drive, active-low, exactly one bit low
//   key_strobe       one-cycle pulse when a press is accepted
//   key_code[3:0]    code of the accepted key (valid with key_strobe)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);

  logic [3:0]       row_s1_q, row_s2_q;
  scan_state_e      state_q, state_d;
  logic [1:0]       k_q, k_d;
  logic [1:0]       ridx_q, ridx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;

  logic       one_low;
  logic       all_high;
  logic [1:0] low_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  // Exactly one row low identifies a key; two or more low is treated as none.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (row_s2_q)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign all_high = (row_s2_q == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      k_q     <= 2'd0;
      ridx_q  <= 2'd0;
      div_q   <= '0;
      db_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ridx_q  <= ridx_d;
      div_q   <= div_d;
      db_q    <= db_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ridx_d     = ridx_q;
    div_d      = div_q;
    db_d       = db_q;
    key_strobe = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (one_low) begin
            // Column stays where it is while the press is qualified.
            state_d = ST_PRESS_DB;
            ridx_d  = low_idx;
            db_d    = '0;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_PRESS_DB: begin
        if (one_low && (low_idx == ridx_q)) begin
          if (db_q == DB_LAST) begin
            key_strobe = 1'b1;
            state_d    = ST_HELD;
            db_d       = '0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          state_d = ST_SCAN;
          db_d    = '0;
        end
      end
      ST_HELD: begin
        if (all_high) begin
          state_d = ST_REL_DB;
          db_d    = '0;
        end
      end
      default: begin // ST_REL_DB
        if (!all_high) begin
          state_d = ST_HELD;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = ST_SCAN;
          k_d     = k_q + 2'd1;
          div_d   = '0;
          db_d    = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
    endcase
  end

  assign col      = ~(4'b0001 << k_q);
  assign key_code = keypad_key_code(ridx_q, k_q);

endmodule

// File: rtl/keypad_decimal_entry.sv
// keypad_decimal_entry: accumulates up to four decimal digits from the
// keypad and, on ENTER, presents their binary value with a one-cycle strobe.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   row[3:0]            keypad rows (active-low, asynchronous)
//   col[3:0]            keypad column drive (active-low)
//   value[11:0]         last entered value, binary
//   value_valid         one-cycle strobe when value updates
//   entry_bcd[15:0]     digits being typed {d3,d2,d1,d0}, d0 most recent
//   digit_count[2:0]    number of digits entered, 0..4
//   key_err             one-cycle strobe when a digit is rejected
module keypad_decimal_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [11:0] value,
  output logic        value_valid,
  output logic [15:0] entry_bcd,
  output logic [2:0]  digit_count,
  output logic        key_err
);

  logic       key_strobe;
  logic [3:0] key_code;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_scanner (
    .clk        (clk),
    .rst_n      (rst_n),
    .row        (row),
    .col        (col),
    .key_strobe (key_strobe),
    .key_code   (key_code)
  );

  logic [15:0] entry_q, entry_d;
  logic [2:0]  count_q, count_d;
  logic [11:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [15:0] candidate;
  logic [13:0] cand_bin;
  logic [13:0] entry_bin;

  // d3 is always 0 whenever a digit can still be accepted, so dropping it
  // in the shift loses nothing.
  assign candidate = {entry_q[11:0], key_code};
  assign cand_bin  = bcd_to_bin(candidate);
  assign entry_bin = bcd_to_bin(entry_q);

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (key_strobe) begin
      if (key_code <= 4'd9) begin
        if ((count_q == 3'd4) || (cand_bin > 14'd4095)) begin
          err_d = 1'b1;
        end else begin
          entry_d = candidate;
          count_d = count_q + 3'd1;
        end
      end else begin
        case (key_code)
          KEY_BKSP: begin
            if (count_q != 3'd0) begin
              entry_d = entry_q >> 4;
              count_d = count_q - 3'd1;
            end
          end
          KEY_CLR: begin
            entry_d = '0;
            count_d = '0;
          end
          KEY_ENTER: begin
            if (count_q != 3'd0) begin
              // Accepted entries never exceed 4095.
              value_d = entry_bin[11:0];
              valid_d = 1'b1;
              entry_d = '0;
              count_d = '0;
            end
          end
          default: ; // *, #, D: no action
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      count_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign entry_bcd   = entry_q;
  assign digit_count = count_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign key_err     = err_q;

endmodule

// File: tb/tb_keypad_decimal_entry.sv
// Directed bench for keypad_decimal_entry with SCAN_DIV = 4, DEBOUNCE_CYC = 8.
// A simple keypad model pulls the selected row low whenever the pressed
// key's column is driven.
module tb_keypad_decimal_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [11:0] value;
  logic        value_valid;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_count;
  logic        key_err;

  keypad_decimal_entry #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .value       (value),
    .value_valid (value_valid),
    .entry_bcd   (entry_bcd),
    .digit_count (digit_count),
    .key_err     (key_err)
  );

  always #5 clk = ~clk;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;

  assign row = (key_down && (col[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

  int n_cmp = 0;
  int n_mis = 0;
  int vv_pulses = 0;
  int err_pulses = 0;

  always @(negedge clk) begin
    if (value_valid) vv_pulses++;
    if (key_err) err_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Key character -> {row, col} on the pad.
  function automatic logic [3:0] pos_of(input byte ch);
    case (ch)
      "1": return 4'h0; "2": return 4'h1; "3": return 4'h2; "A": return 4'h3;
      "4": return 4'h4; "5": return 4'h5; "6": return 4'h6; "B": return 4'h7;
      "7": return 4'h8; "8": return 4'h9; "9": return 4'hA; "C": return 4'hB;
      "*": return 4'hC; "0": return 4'hD; "#": return 4'hE; default: return 4'hF;
    endcase
  endfunction

  task automatic select_key(input byte ch);
    logic [3:0] p;
    p = pos_of(ch);
    key_r = p[3:2];
    key_c = p[1:0];
  endtask

  task automatic press(input byte ch, input int hold);
    select_key(ch);
    key_down = 1'b1;
    repeat (hold) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) press(s[i], 60);
  endtask

  logic [3:0] exp_col;
  int vv0, err0;

  initial begin
    // Reset and idle column rotation.
    repeat (3) @(negedge clk);
    check_eq("rst_value", {20'd0, value}, 32'd0);
    check_eq("rst_valid", {31'd0, value_valid}, 32'd0);
    check_eq("rst_entry", {16'd0, entry_bcd}, 32'd0);
    check_eq("rst_count", {29'd0, digit_count}, 32'd0);
    check_eq("rst_err", {31'd0, key_err}, 32'd0);
    check_eq("rst_col", {28'd0, col}, 32'hE);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      check_eq($sformatf("idle_col%0d", i), {28'd0, col}, {28'd0, exp_col});
      @(negedge clk);
    end
    check_eq("idle_entry", {16'd0, entry_bcd}, 32'd0);

    // 4095 then ENTER.
    type_str("4095");
    check_eq("e4095_entry", {16'd0, entry_bcd}, 32'h4095);
    check_eq("e4095_count", {29'd0, digit_count}, 32'd4);
    vv0 = vv_pulses;
    type_str("A");
    check_eq("e4095_value", {20'd0, value}, 32'd4095);
    check_eq("e4095_vv", vv_pulses - vv0, 32'd1);
    check_eq("e4095_clr", {16'd0, entry_bcd}, 32'd0);
    check_eq("e4095_cnt0", {29'd0, digit_count}, 32'd0);

    // 4096 overflow rejected.
    err0 = err_pulses;
    type_str("4096");
    check_eq("ovf_err", err_pulses - err0, 32'd1);
    check_eq("ovf_entry", {16'd0, entry_bcd}, 32'h0409);
    check_eq("ovf_count", {29'd0, digit_count}, 32'd3);

    // Fifth digit rejected.
    err0 = err_pulses;
    type_str("C12345");
    check_eq("full_err", err_pulses - err0, 32'd1);
    check_eq("full_entry", {16'd0, entry_bcd}, 32'h1234);
    check_eq("full_count", {29'd0, digit_count}, 32'd4);

    // Backspace and enter.
    vv0 = vv_pulses;
    type_str("C73B2A");
    check_eq("bk_value", {20'd0, value}, 32'd72);
    check_eq("bk_vv", vv_pulses - vv0, 32'd1);
    type_str("11C");
    check_eq("clr_count", {29'd0, digit_count}, 32'd0);
    check_eq("clr_entry", {16'd0, entry_bcd}, 32'd0);
    vv0 = vv_pulses;
    type_str("A");
    check_eq("empty_vv", vv_pulses - vv0, 32'd0);
    check_eq("empty_value", {20'd0, value}, 32'd72);

    // Bouncing contact then stable press of 8.
    select_key("8");
    for (int i = 0; i < 10; i++) begin
      key_down = ~key_down;
      repeat (3) @(negedge clk);
    end
    key_down = 1'b1;
    repeat (60) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("bounce_entry", {16'd0, entry_bcd}, 32'h0008);
    check_eq("bounce_count", {29'd0, digit_count}, 32'd1);

    // Long hold: no auto-repeat.
    press("3", 200);
    check_eq("hold_entry", {16'd0, entry_bcd}, 32'h0083);
    check_eq("hold_count", {29'd0, digit_count}, 32'd2);

    // Reset while holding 5.
    select_key("5");
    key_down = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("pre_rst_entry", {16'd0, entry_bcd}, 32'h0835);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_entry", {16'd0, entry_bcd}, 32'd0);
    check_eq("mid_rst_count", {29'd0, digit_count}, 32'd0);
    check_eq("mid_rst_value", {20'd0, value}, 32'd0);
    check_eq("mid_rst_col", {28'd0, col}, 32'hE);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    key_down = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("post_rst_entry", {16'd0, entry_bcd}, 32'h0005);
    check_eq("post_rst_count", {29'd0, digit_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
